// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the 1-to-8 TDM demultiplexer.
// Latency: none (definitions only). Backpressure: not applicable.
// Flow control: not applicable.
package tdm_demux_pkg;

    localparam int NUM_CH_DEF  = 8;
    localparam int SEL_W_DEF   = 3;
    // Slot index of the trailing even-parity beat when parity framing is built in.
    localparam int PARITY_SLOT = NUM_CH_DEF;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux_1to8_if.sv
// Serial-in / parallel-out bundle between the link front end and the TDM demux.
// Latency: none (wiring only). Backpressure: none, the stream is qualified by din_valid only.
// Flow control: the receiver always accepts; there is no ready signal.
interface tdm_demux_1to8_if
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF
) ();

    logic              din_valid;
    logic              din;
    logic              frame_sync;
    logic [NUM_CH-1:0] dout;
    logic              dout_valid;
    logic [SEL_W-1:0]  slot;
    logic              frame_err;
    logic              parity_err;

    modport master (
        output din_valid, din, frame_sync,
        input  dout, dout_valid, slot, frame_err, parity_err
    );

    modport slave (
        input  din_valid, din, frame_sync,
        output dout, dout_valid, slot, frame_err, parity_err
    );

endinterface

// File: rtl/tdm_demux_1to8_decoder_3to8.sv
// Select-to-one-hot decoder with enable; drives the shadow-register write strobes.
// Latency: combinational. Backpressure: none.
// Flow control: not applicable.
module decoder_3to8
    import tdm_demux_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int N     = 2 ** SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_1to8.sv
// TDM 1-to-8 demux: rebuilds parallel channel bits from a sync-framed serial stream.
// Latency: dout/dout_valid registered, visible the cycle after the final beat; errors likewise.
// Backpressure: none; din_valid=0 freezes all state. Optional parity beat: TDM_DEMUX_PARITY_EN.
module tdm_demux_1to8
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    tdm_demux_1to8_if.slave  bus
);

`ifdef TDM_DEMUX_PARITY_EN
    // One extra counter bit so the parity beat gets its own slot past NUM_CH-1.
    localparam int CNT_W     = SEL_W + 1;
    localparam int LAST_SLOT = NUM_CH;
`else
    localparam int CNT_W     = SEL_W;
    localparam int LAST_SLOT = NUM_CH - 1;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  shadow_q;
    logic [NUM_CH-1:0]  wr_strb;
    logic               wr_en;
    logic [SEL_W-1:0]   wr_sel;
    logic [NUM_CH-1:0]  dout_d;
    logic               dout_valid_d;
    logic               frame_err_d;
    logic               parity_err_d;

    decoder_3to8 #(
        .SEL_W (SEL_W),
        .N     (NUM_CH)
    ) u_dec (
        .sel    (wr_sel),
        .en     (wr_en),
        .onehot (wr_strb)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dout_d       = bus.dout;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        wr_en        = 1'b0;
        wr_sel       = cnt_q[SEL_W-1:0];

        if (bus.din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        wr_en   = 1'b1;
                        wr_sel  = '0;
                        cnt_d   = CNT_W'(1);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        if (bus.frame_sync) begin
                            wr_en  = 1'b1;
                            wr_sel = '0;
                            cnt_d  = CNT_W'(1);
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = HUNT;
                            cnt_d       = '0;
                        end
                    end else if (bus.frame_sync) begin
                        // Early sync: restart alignment on this beat as slot 0.
                        frame_err_d = 1'b1;
                        wr_en       = 1'b1;
                        wr_sel      = '0;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(LAST_SLOT)) begin
                        cnt_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        dout_d = shadow_q;
                        if (bus.din != (^shadow_q)) begin
                            parity_err_d = 1'b1;
                        end else begin
                            dout_valid_d = 1'b1;
                        end
`else
                        wr_en                = 1'b1;
                        dout_d               = shadow_q;
                        dout_d[NUM_CH-1]     = bus.din;
                        dout_valid_d         = 1'b1;
`endif
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= HUNT;
            cnt_q          <= '0;
            shadow_q       <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus.dout       <= dout_d;
            bus.dout_valid <= dout_valid_d;
            bus.frame_err  <= frame_err_d;
            bus.parity_err <= parity_err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_strb[i]) begin
                    shadow_q[i] <= bus.din;
                end
            end
        end
    end

    assign bus.slot = cnt_q[SEL_W-1:0];

endmodule
